mbox_pkt_framer: RTL and testbench

//  Downstream stage of the SFIFO/WISHBONE interface's MAILBOX port. Accepts the byte stream
//  (mbox_wr/mbox_do) and buffers it in a byte FIFO. Returns full/almost-full backpressure to
//  the producer. Frames buffered bytes into WOU mailbox packets on a valid/ready byte link

---
 rtl/mbox_pkt_framer.sv | 202 ++++++++++++++++++++
 tb/tb_mbox_pkt_framer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_pkt_framer.sv
// mbox_pkt_framer: buffers mailbox bytes in a first-word-fall-through FIFO and
// frames them into WOU mailbox packets (SYNC, TYPE, LEN, payload, CSUM) on a
// valid/ready byte link. Full/almost-full flags give backpressure upstream.
module mbox_pkt_framer #(
    parameter int                WOU_DW    = 8,
    parameter int                FIFO_AW   = 4,
    parameter int                AFULL_LVL = 12,
    parameter int                MAX_PLD   = 8,
    parameter int                IDLE_TO   = 64,
    parameter logic [WOU_DW-1:0] SYNC_BYTE = 8'h55,
    parameter logic [WOU_DW-1:0] PKT_TYPE  = 8'hA5
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mbox_wr_i,
    input  logic [WOU_DW-1:0] mbox_do_i,
    output logic              mbox_full_o,
    output logic              mbox_afull_o,
    output logic [WOU_DW-1:0] tx_dat_o,
    output logic              tx_vld_o,
    input  logic              tx_rdy_i,
    output logic              ovf_o,
    output logic [15:0]       pkt_cnt_o
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int IDL_W = $clog2(IDLE_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_TYPE,
        S_LEN,
        S_PLD,
        S_CSUM
    } state_e;

    logic [WOU_DW-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [IDL_W-1:0]   idle_q;
    logic [IDL_W-1:0]   idle_d;
    logic               full_q;
    logic               afull_q;
    logic               ovf_q;

    state_e             state_q;
    logic [WOU_DW-1:0]  tx_dat_q;
    logic               tx_vld_q;
    logic [WOU_DW-1:0]  len_q;
    logic [WOU_DW-1:0]  len_d;
    logic [WOU_DW-1:0]  rem_q;
    logic [WOU_DW-1:0]  csum_q;
    logic [15:0]        pkt_cnt_q;

    logic               wr_acc;
    logic               pop;
    logic               trigger;

    // A byte is taken only while the registered full flag is low; the head is
    // popped exactly when a payload byte is accepted downstream.
    assign wr_acc     = mbox_wr_i & ~full_q;
    assign pop        = (state_q == S_PLD) & tx_rdy_i;
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    // Next fill count, idle timer, packet trigger and latched length.
    always_comb begin
        // NOTE: every signal gets a default at the top so no latch is inferred.
        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        idle_d = idle_q;
        if (wr_acc || count_q == '0) begin
            idle_d = '0;
        end else if (idle_q != IDL_W'(IDLE_TO)) begin
            idle_d = idle_q + 1'b1;
        end

        trigger = (int'(count_q) >= MAX_PLD) ||
                  ((count_q != '0) && (idle_q == IDL_W'(IDLE_TO)));
        len_d   = (int'(count_q) >= MAX_PLD) ? WOU_DW'(MAX_PLD) : WOU_DW'(count_q);
    end

    // FIFO byte storage.
    // NOTE: the array is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= mbox_do_i;
        end
    end

    // FIFO pointers, fill count, registered flags, sticky overflow and idle timer.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            idle_q   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_d;
            full_q  <= (int'(count_d) == DEPTH);
            afull_q <= (int'(count_d) >= AFULL_LVL);
            ovf_q   <= ovf_q | (mbox_wr_i & full_q);
            idle_q  <= idle_d;
        end
    end

    // Packet framer: one byte per state, advancing only on acceptance, with
    // the checksum accumulated from TYPE, LEN and each accepted payload byte.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            tx_dat_q  <= '0;
            tx_vld_q  <= 1'b0;
            len_q     <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q  <= S_SYNC;
                        tx_vld_q <= 1'b1;
                        tx_dat_q <= SYNC_BYTE;
                        len_q    <= len_d;
                        csum_q   <= PKT_TYPE + len_d;
                    end
                end
                S_SYNC: begin
                    if (tx_rdy_i) begin
                        state_q  <= S_TYPE;
                        tx_dat_q <= PKT_TYPE;
                    end
                end
                S_TYPE: begin
                    if (tx_rdy_i) begin
                        state_q  <= S_LEN;
                        tx_dat_q <= len_q;
                    end
                end
                S_LEN: begin
                    if (tx_rdy_i) begin
                        state_q  <= S_PLD;
                        tx_dat_q <= mem[rd_ptr_q];
                        rem_q    <= len_q;
                    end
                end
                S_PLD: begin
                    if (tx_rdy_i) begin
                        csum_q <= csum_q + tx_dat_q;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == WOU_DW'(1)) begin
                            state_q  <= S_CSUM;
                            tx_dat_q <= csum_q + tx_dat_q;
                        end else begin
                            tx_dat_q <= mem[rd_ptr_nxt];
                        end
                    end
                end
                S_CSUM: begin
                    if (tx_rdy_i) begin
                        state_q   <= S_IDLE;
                        tx_vld_q  <= 1'b0;
                        tx_dat_q  <= '0;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    tx_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign mbox_full_o  = full_q;
    assign mbox_afull_o = afull_q;
    assign ovf_o        = ovf_q;
    assign tx_dat_o     = tx_dat_q;
    assign tx_vld_o     = tx_vld_q;
    assign pkt_cnt_o    = pkt_cnt_q;

endmodule

// File: tb/tb_mbox_pkt_framer.sv
// Self-checking bench for mbox_pkt_framer. Expected tx bytes come from a
// packet-level model: each packet is SYNC, TYPE, LEN, payload, and the byte
// sum of TYPE, LEN and payload. Inputs change on the falling edge and
// outputs are sampled there too.
module tb_mbox_pkt_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mbox_wr = 1'b0;
    logic [7:0]  mbox_do = 8'h00;
    logic        tx_rdy = 1'b0;
    logic        full;
    logic        afull;
    logic [7:0]  dat;
    logic        vld;
    logic        ovf;
    logic [15:0] pkt_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    bit          exp_last[$];
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    mbox_pkt_framer dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .mbox_wr_i    (mbox_wr),
        .mbox_do_i    (mbox_do),
        .mbox_full_o  (full),
        .mbox_afull_o (afull),
        .tx_dat_o     (dat),
        .tx_vld_o     (vld),
        .tx_rdy_i     (tx_rdy),
        .ovf_o        (ovf),
        .pkt_cnt_o    (pkt_cnt)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a falling edge; holds the write across one rising edge.
    task automatic wr_byte(input logic [7:0] b);
        mbox_wr = 1'b1;
        mbox_do = b;
        @(negedge clk);
        mbox_wr = 1'b0;
    endtask

    // Reference model: append one complete packet for the given payload.
    task automatic push_pkt(input logic [7:0] pld[$]);
        int sum;
        sum = 'hA5 + pld.size();
        exp_q.push_back(8'h55);          exp_last.push_back(1'b0);
        exp_q.push_back(8'hA5);          exp_last.push_back(1'b0);
        exp_q.push_back(8'(pld.size())); exp_last.push_back(1'b0);
        foreach (pld[i]) begin
            exp_q.push_back(pld[i]);
            exp_last.push_back(1'b0);
            sum += int'(pld[i]);
        end
        exp_q.push_back(8'(sum));
        exp_last.push_back(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_last.delete();
        exp_cnt = 16'd0;
    endtask

    // Consume n tx bytes against the model, checking hold-while-stalled and
    // the idle gap after each checksum byte.
    task automatic drain(input int n, input int rdy_pct, input int stall_at,
                         input int stall_len, output int span);
        int         got, cyc, stall_left, first;
        bit         prev_hold, gap_due, stalled, l;
        logic [7:0] prev_dat, e;
        got = 0; cyc = 0; stall_left = 0; first = -1; span = 0;
        prev_hold = 1'b0; gap_due = 1'b0; stalled = 1'b0; prev_dat = 8'h00;
        while (got < n && cyc < 5000) begin
            if (got == stall_at && !stalled && vld === 1'b1) begin
                stall_left = stall_len;
                stalled    = 1'b1;
            end
            if (stall_left > 0) begin
                tx_rdy = 1'b0;
                stall_left--;
            end else begin
                tx_rdy = ($urandom_range(1, 100) <= rdy_pct);
            end
            if (prev_hold) begin
                n_chk++;
                if (vld !== 1'b1 || dat !== prev_dat) begin
                    n_err++;
                    $display("FAIL tx_hold: vld=%b dat=%h, required vld=1 dat=%h", vld, dat, prev_dat);
                end
            end
            if (gap_due) begin
                n_chk++;
                if (vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL tx_gap: vld=%b after checksum, required 0", vld);
                end
            end
            gap_due = 1'b0;
            if (vld === 1'b1 && first < 0) first = cyc;
            if (vld === 1'b1 && tx_rdy) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_extra: unexpected byte %h", dat);
                end else begin
                    e = exp_q.pop_front();
                    l = exp_last.pop_front();
                    if (dat !== e) begin
                        n_err++;
                        $display("FAIL tx_byte[%0d]: got %h, required %h", got, dat, e);
                    end
                    if (l) begin
                        gap_due = 1'b1;
                        exp_cnt++;
                    end
                end
                got++;
                span = cyc - first + 1;
            end
            prev_hold = (vld === 1'b1) && !tx_rdy;
            prev_dat  = dat;
            @(negedge clk);
            cyc++;
        end
        tx_rdy = 1'b0;
        if (gap_due) begin
            n_chk++;
            if (vld !== 1'b0) begin
                n_err++;
                $display("FAIL tx_gap: vld=%b after checksum, required 0", vld);
            end
        end
        if (got < n) begin
            n_chk++;
            n_err++;
            $display("FAIL tx_timeout: accepted %0d bytes, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({vld, full, afull, ovf, dat, pkt_cnt} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs: vld=%b full=%b afull=%b ovf=%b dat=%h cnt=%h, required all 0",
                     vld, full, afull, ovf, dat, pkt_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (vld !== 1'b0 || full !== 1'b0 || pkt_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_release: vld=%b full=%b cnt=%h, required 0 0 0", vld, full, pkt_cnt);
        end
    endtask

    task automatic test_full_packet();
        logic [7:0] pld[$];
        int         span;
        for (int i = 1; i <= 8; i++) pld.push_back(8'(i));
        foreach (pld[i]) wr_byte(pld[i]);
        push_pkt(pld);
        drain(12, 100, -1, 0, span);
        n_chk++;
        if (span !== 12) begin
            n_err++;
            $display("FAIL pkt_span: %0d cycles, required 12", span);
        end
        n_chk++;
        if (pkt_cnt !== exp_cnt || full !== 1'b0) begin
            n_err++;
            $display("FAIL pkt_cnt_full: cnt=%h full=%b, required cnt=%h full=0", pkt_cnt, full, exp_cnt);
        end
    endtask

    task automatic test_idle_flush();
        logic [7:0] pld[$];
        int         span, seen;
        pld = '{8'h10, 8'h20, 8'h30};
        foreach (pld[i]) wr_byte(pld[i]);
        seen = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (vld === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL idle_early: vld seen %0d cycles before timeout, required 0", seen);
        end
        @(negedge clk);
        n_chk++;
        if (vld !== 1'b1 || dat !== 8'h55) begin
            n_err++;
            $display("FAIL idle_flush_sync: vld=%b dat=%h, required vld=1 dat=55", vld, dat);
        end
        push_pkt(pld);
        drain(7, 100, -1, 0, span);
        n_chk++;
        if (pkt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL idle_pkt_cnt: got %h, required %h", pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_stall();
        logic [7:0] pld[$];
        int         span;
        for (int i = 0; i < 8; i++) pld.push_back(8'($urandom));
        foreach (pld[i]) wr_byte(pld[i]);
        push_pkt(pld);
        drain(12, 100, 5, 20, span);
        n_chk++;
        if (span !== 32) begin
            n_err++;
            $display("FAIL stall_span: %0d cycles, required 32", span);
        end
    endtask

    task automatic test_random_stream();
        int span;
        fork
            begin : producer
                logic [7:0] pld[$];
                logic [7:0] b;
                int         guard;
                for (int i = 0; i < 48; i++) begin
                    b = 8'($urandom);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    guard = 0;
                    while (full === 1'b1 && guard < 2000) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 2000) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL producer_timeout: full never cleared");
                    end
                    wr_byte(b);
                    pld.push_back(b);
                    if (pld.size() == 8) begin
                        push_pkt(pld);
                        pld.delete();
                    end
                end
            end
            drain(72, 60, -1, 0, span);
        join
        n_chk++;
        if (pkt_cnt !== exp_cnt || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL random_cnt: cnt=%h ovf=%b, required cnt=%h ovf=0", pkt_cnt, ovf, exp_cnt);
        end
    endtask

    task automatic test_same_cycle_pop_write();
        logic [7:0] p1[$];
        logic [7:0] p2[$];
        logic [7:0] e;
        bit         l;
        int         span;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            e = 8'($urandom);
            wr_byte(e);
            if (i < 8) p1.push_back(e); else p2.push_back(e);
        end
        n_chk++;
        if (full !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL pw_full: full=%b ovf=%b, required full=1 ovf=0", full, ovf);
        end
        push_pkt(p1);
        push_pkt(p2);
        for (int k = 0; k < 4; k++) begin
            tx_rdy = 1'b1;
            if (k == 3) begin
                mbox_wr = 1'b1;
                mbox_do = 8'hEE;
            end
            e = exp_q.pop_front();
            l = exp_last.pop_front();
            n_chk++;
            if (vld !== 1'b1 || dat !== e) begin
                n_err++;
                $display("FAIL pw_head[%0d]: vld=%b dat=%h, required vld=1 dat=%h", k, vld, dat, e);
            end
            @(negedge clk);
        end
        mbox_wr = 1'b0;
        tx_rdy  = 1'b0;
        n_chk++;
        if (ovf !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL pw_drop: ovf=%b full=%b, required ovf=1 full=0", ovf, full);
        end
        drain(20, 100, -1, 0, span);
        n_chk++;
        if (pkt_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL pw_pkt_cnt: got %h, required %h", pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure_fill();
        logic [7:0] p1[$];
        logic [7:0] p2[$];
        logic [7:0] b;
        int         span;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            b = 8'($urandom);
            wr_byte(b);
            if (i <= 8) p1.push_back(b); else if (i <= 16) p2.push_back(b);
            n_chk++;
            if (afull !== (i >= 12) || full !== (i >= 16) || ovf !== (i == 17)) begin
                n_err++;
                $display("FAIL fill[%0d]: afull=%b full=%b ovf=%b, required %b %b %b",
                         i, afull, full, ovf, i >= 12, i >= 16, i == 17);
            end
        end
        push_pkt(p1);
        push_pkt(p2);
        drain(24, 100, -1, 0, span);
        n_chk++;
        if (pkt_cnt !== exp_cnt || full !== 1'b0 || afull !== 1'b0) begin
            n_err++;
            $display("FAIL fill_done: cnt=%h full=%b afull=%b, required cnt=%h 0 0",
                     pkt_cnt, full, afull, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] pld[$];
        logic [7:0] e;
        bit         l;
        int         span;
        for (int i = 0; i < 8; i++) pld.push_back(8'($urandom));
        foreach (pld[i]) wr_byte(pld[i]);
        push_pkt(pld);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tx_rdy = 1'b1;
            e = exp_q.pop_front();
            l = exp_last.pop_front();
            n_chk++;
            if (vld !== 1'b1 || dat !== e) begin
                n_err++;
                $display("FAIL rst_pre[%0d]: vld=%b dat=%h, required vld=1 dat=%h", k, vld, dat, e);
            end
            @(negedge clk);
        end
        tx_rdy = 1'b0;
        rst    = 1'b1;
        #1;
        n_chk++;
        if ({vld, full, afull, ovf, dat, pkt_cnt} !== 28'd0) begin
            n_err++;
            $display("FAIL rst_mid: vld=%b full=%b afull=%b ovf=%b dat=%h cnt=%h, required all 0",
                     vld, full, afull, ovf, dat, pkt_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_last.delete();
        exp_cnt = 16'd0;
        pld.delete();
        for (int i = 0; i < 8; i++) pld.push_back(8'($urandom));
        foreach (pld[i]) wr_byte(pld[i]);
        push_pkt(pld);
        drain(12, 100, -1, 0, span);
        n_chk++;
        if (pkt_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL rst_clean_cnt: got %h, required 0001", pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_idle_flush();
        test_stall();
        test_random_stream();
        test_same_cycle_pop_write();
        test_backpressure_fill();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
